div_seq_macro: RTL

//  Unsigned iterative restoring divider, the inverse companion of the pipelined multiplier macro.

---
 rtl/dds_pkg.sv | 21 ++
 rtl/div_step.sv | 27 ++
 rtl/div_seq_macro.sv | 107 ++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared FSM state encodings and width helper for the DDS control path
package dds_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        CALC   = ST_CALC,
        DONE_S = ST_DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step, MSB first
module div_step
    import dds_pkg::*;
#(
    parameter int WIDTH_D = 16
) (
    input  logic [WIDTH_D-1:0] rem_in,
    input  logic               n_msb,
    input  logic [WIDTH_D-1:0] d,
    output logic [WIDTH_D-1:0] rem_out,
    output logic               qbit
);

    logic [WIDTH_D:0] t;
    logic [WIDTH_D:0] dx;
    logic [WIDTH_D:0] diff;

    // trial subtraction on WIDTH_D+1 bits so divisors near full scale never overflow
    always_comb begin
        t       = {rem_in, n_msb};
        dx      = {1'b0, d};
        diff    = t - dx;
        qbit    = t >= dx;
        rem_out = WIDTH_D'(qbit ? diff : t);
    end

endmodule

// File: rtl/div_seq_macro.sv
// div_seq_macro: unsigned iterative restoring divider with START/READY/DONE handshake
module div_seq_macro
    import dds_pkg::*;
#(
    parameter int WIDTH_N = 32,
    parameter int WIDTH_D = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CE,
    input  logic               START,
    input  logic [WIDTH_N-1:0] N,
    input  logic [WIDTH_D-1:0] D,
    output logic               READY,
    output logic               BUSY,
    output logic               DONE,
    output logic [WIDTH_N-1:0] Q,
    output logic [WIDTH_D-1:0] R,
    output logic               DIV0
);

    localparam int CW = clog2(WIDTH_N);
    localparam logic [CW-1:0] LAST = CW'(WIDTH_N - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH_N-1:0] n_sh;
    logic [WIDTH_D-1:0] rem;
    logic [WIDTH_D-1:0] d_r;
    logic [WIDTH_D-1:0] rem_next;
    logic               qbit;

    div_step #(.WIDTH_D(WIDTH_D)) u_step (
        .rem_in (rem),
        .n_msb  (n_sh[WIDTH_N-1]),
        .d      (d_r),
        .rem_out(rem_next),
        .qbit   (qbit)
    );

    // control FSM with datapath registers; results only become visible on the final step
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            n_sh  <= '0;
            rem   <= '0;
            d_r   <= '0;
            Q     <= '0;
            R     <= '0;
            DIV0  <= 1'b0;
            DONE  <= 1'b0;
            BUSY  <= 1'b0;
            READY <= 1'b1;
        end else if (CE) begin
            case (state)
                IDLE, DONE_S: begin
                    if (START && D != '0) begin
                        n_sh  <= N;
                        d_r   <= D;
                        rem   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                        DONE  <= 1'b0;
                        BUSY  <= 1'b1;
                        READY <= 1'b0;
                    end else if (START) begin
                        Q     <= '1;
                        R     <= '0;
                        DIV0  <= 1'b1;
                        state <= DONE_S;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        READY <= 1'b1;
                    end else begin
                        state <= IDLE;
                        DONE  <= 1'b0;
                        BUSY  <= 1'b0;
                        READY <= 1'b1;
                    end
                end
                CALC: begin
                    n_sh <= {n_sh[WIDTH_N-2:0], qbit};
                    rem  <= rem_next;
                    if (cnt == LAST) begin
                        Q     <= {n_sh[WIDTH_N-2:0], qbit};
                        R     <= rem_next;
                        DIV0  <= 1'b0;
                        state <= DONE_S;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        READY <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    READY <= 1'b1;
                end
            endcase
        end
    end

endmodule
